// File: rtl/burst_sequencer.sv
// -----------------------------------------------------------------------------
// burst_sequencer
//
// Holds a small table of burst descriptors (packet_count, packet_length,
// idle_cycles, initial_value). On go it walks the table and sends one burst per
// slot to the packet generator. Each burst drives the gen_* config outputs and
// a one-cycle gen_start pulse. The sequencer then waits for gen_busy to drop.
// It inserts gap_cycles idle clocks between bursts and repeats the whole table
// loop_count times. A loop_count of 0 repeats the table until abort.
//
// Ports:
//   clk, resetn          single clock, asynchronous active-low reset
//   cfg_we/addr/field/   descriptor field write, accepted only while idle
//   cfg_wdata
//   num_entries          slots used per pass (0..ENTRIES)
//   loop_count           passes over the table, 0 = until abort
//   gap_cycles           idle clocks between bursts
//   go, abort            start pulse / stop request
//   busy, done, aborted  status; done/aborted are one-cycle pulses
//   cur_entry, cur_pass  slot being run, 1-based pass number
//   gen_*                config and start pulse to the generator; gen_busy back
//   stat_bursts,         launch / launched-packet counters
//   stat_packets
//
// Optional feature: define BURST_SEQ_STATS_EN to build the statistics
// counters. Without it, stat_bursts and stat_packets are tied to 0.
// -----------------------------------------------------------------------------
module burst_sequencer #(
  parameter  int ENTRIES = 8,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [1:0]    cfg_field,
  input  logic [31:0]   cfg_wdata,
  input  logic [AW:0]   num_entries,
  input  logic [15:0]   loop_count,
  input  logic [15:0]   gap_cycles,
  input  logic          go,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] cur_entry,
  output logic [15:0]   cur_pass,
  output logic [31:0]   gen_packet_count,
  output logic [15:0]   gen_packet_length,
  output logic [15:0]   gen_idle_cycles,
  output logic [15:0]   gen_initial_value,
  output logic          gen_start,
  input  logic          gen_busy,
  output logic [31:0]   stat_bursts,
  output logic [47:0]   stat_packets
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_RUN,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // Descriptor table
  logic [31:0] pc_mem   [ENTRIES];
  logic [15:0] len_mem  [ENTRIES];
  logic [15:0] idle_mem [ENTRIES];
  logic [15:0] iv_mem   [ENTRIES];

  // Run context latched on go
  logic [AW:0]   n_q;
  logic [15:0]   loop_q;
  logic [15:0]   gap_q;
  logic [AW-1:0] entry_q;
  logic [15:0]   pass_q;
  logic [15:0]   gap_cnt_q;
  logic          first_q;    // first cycle of RUN/DRAIN: gen_busy not yet trustworthy
  logic          done_q;
  logic          aborted_q;

  // Decode helpers
  logic          go_accept;
  logic [AW:0]   entry_inc;
  logic          last_entry;
  logic          final_pass;
  logic          final_burst;
  logic          skip_entry;

  // Control strobes from the next-state logic
  logic          adv;
  logic          finish;
  logic          abort_fin;
  logic          gap_load;

  assign go_accept   = (state_q == S_IDLE) && go;
  assign entry_inc   = {1'b0, entry_q} + {{AW{1'b0}}, 1'b1};
  assign last_entry  = (entry_inc >= n_q);
  assign final_pass  = (loop_q != 16'd0) && (pass_q == loop_q);
  // No gap is inserted after the very last burst, so done follows its busy-low directly.
  assign final_burst = last_entry && final_pass;
  assign skip_entry  = (pc_mem[entry_q] == 32'd0) || (len_mem[entry_q] == 16'd0);

  // NOTE: the descriptor table has no reset. It is plain storage that software
  // fills before use, and leaving it out of reset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) begin
      case (cfg_field)
        2'd0: pc_mem[cfg_addr]   <= cfg_wdata;
        2'd1: len_mem[cfg_addr]  <= cfg_wdata[15:0];
        2'd2: idle_mem[cfg_addr] <= cfg_wdata[15:0];
        2'd3: iv_mem[cfg_addr]   <= cfg_wdata[15:0];
        default: ;
      endcase
    end
  end

  // Next-state logic
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    adv       = 1'b0;
    finish    = 1'b0;
    abort_fin = 1'b0;
    gap_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go && (num_entries != '0)) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          state_d   = S_IDLE;
          abort_fin = 1'b1;
        end else if (skip_entry) begin
          adv = 1'b1;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // The start pulse is already out, so an abort here must drain the generator.
        state_d = abort ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else if (!first_q && !gen_busy) begin
          if ((gap_q != 16'd0) && !final_burst) begin
            state_d  = S_GAP;
            gap_load = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          abort_fin = 1'b1;
        end else if (gap_cnt_q == 16'd0) begin
          adv = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!first_q && !gen_busy) begin
          state_d   = S_IDLE;
          abort_fin = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (!last_entry) begin
        state_d = S_FETCH;
      end else if (final_pass) begin
        state_d = S_IDLE;
        finish  = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // State and run context
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values present before the clock edge, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      loop_q    <= '0;
      gap_q     <= '0;
      entry_q   <= '0;
      pass_q    <= '0;
      gap_cnt_q <= '0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= (state_q == S_LAUNCH);
      done_q    <= finish || (go_accept && (num_entries == '0));
      aborted_q <= abort_fin;

      if (go_accept && (num_entries != '0)) begin
        n_q     <= num_entries;
        loop_q  <= loop_count;
        gap_q   <= gap_cycles;
        entry_q <= '0;
        pass_q  <= 16'd1;
      end

      if (gap_load) begin
        gap_cnt_q <= gap_q - 16'd1;
      end else if ((state_q == S_GAP) && (gap_cnt_q != 16'd0)) begin
        gap_cnt_q <= gap_cnt_q - 16'd1;
      end

      if (adv) begin
        if (!last_entry) begin
          entry_q <= entry_inc[AW-1:0];
        end else if (!final_pass) begin
          // pass_q may wrap when loop_count is 0 (run until abort).
          entry_q <= '0;
          pass_q  <= pass_q + 16'd1;
        end
      end
    end
  end

  // Generator config: captured in FETCH and held until the next FETCH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_packet_count  <= '0;
      gen_packet_length <= '0;
      gen_idle_cycles   <= '0;
      gen_initial_value <= '0;
    end else if (state_q == S_FETCH) begin
      gen_packet_count  <= pc_mem[entry_q];
      gen_packet_length <= len_mem[entry_q];
      gen_idle_cycles   <= idle_mem[entry_q];
      gen_initial_value <= iv_mem[entry_q];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign gen_start = (state_q == S_LAUNCH);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cur_entry = entry_q;
  assign cur_pass  = pass_q;

`ifdef BURST_SEQ_STATS_EN
  logic [31:0] bursts_q;
  logic [47:0] packets_q;
  logic [48:0] packets_sum;

  // One extra bit catches overflow so the packet total can saturate.
  assign packets_sum = {1'b0, packets_q} + {17'd0, gen_packet_count};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bursts_q  <= '0;
      packets_q <= '0;
    end else if (go_accept) begin
      bursts_q  <= '0;
      packets_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      if (bursts_q != '1) bursts_q <= bursts_q + 32'd1;
      packets_q <= packets_sum[48] ? '1 : packets_sum[47:0];
    end
  end

  assign stat_bursts  = bursts_q;
  assign stat_packets = packets_q;
`else
  assign stat_bursts  = '0;
  assign stat_packets = '0;
`endif

endmodule
